signal_sync_edge_flags: RTL and testbench
=========================================

// Module: signal_sync_edge_flags
// PURPOSE
//  Multi-channel synchroniser and event-flag generator for asynchronous drive/host signals (INDEX, TRACK0, WRPROT, ...).
//  Brings CHANNELS async inputs into the clk domain, glitch-filters them, and detects per-channel selectable edges.
//  Emits a one-cycle pulse and a sticky flag per edge, for the control/status registers and the acquisition FSMs.
// PARAMETERS
//  CHANNELS     4  number of independent input channels (>=1)
//  SYNC_STAGES  2  metastability flops per channel (>=2)
//  FILTER_LEN   4  consecutive clk cycles a new synced level must hold before acceptance (>=1; 1 = no filtering)
// PORTS
//  clk        in   1            system clock; all logic on posedge
//  reset_n    in   1            asynchronous, active-low reset
//  sig_in     in   CHANNELS     asynchronous input signals
//  edge_mode  in   2*CHANNELS   per channel [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
//  flag_clr   in   CHANNELS     per-channel sticky flag clear, one clk cycle per request
//  level_out  out  CHANNELS     synchronised, filtered level
//  pulse_out  out  CHANNELS     one-cycle pulse per selected edge
//  flag_out   out  CHANNELS     sticky edge flag
//  ovr_out    out  CHANNELS     sticky overrun flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all sync flops, level_out, filter counters, pulse_out, flag_out, ovr_out = 0, asynchronously.
//   A channel held high through reset release therefore yields one rising event after full latency.
//  Sync: SYNC_STAGES-deep shift chain per channel; sync_q = last stage. No logic between the stages.
//  Filter (per channel): counter width $clog2(FILTER_LEN)+1.
//   sync_q == level_out: cnt <= 0.
//   sync_q != level_out and cnt == FILTER_LEN-1: level_out <= sync_q, cnt <= 0, transition this cycle.
//   Otherwise cnt <= cnt+1.
//   A differing run shorter than FILTER_LEN cycles is discarded: no level change, no pulse.
//  Latency: input change is first captured at edge 1. level_out and pulse_out change at edge SYNC_STAGES+FILTER_LEN.
//   Default: 6 clk cycles. Fixed latency; no dependency on other channels.
//  Edge detect: on a transition cycle pulse_out[i] <= 1 when
//   (new level 1 and edge_mode bit0) or (new level 0 and edge_mode bit1); otherwise pulse_out[i] <= 0.
//   Registered, high exactly one cycle.
//   edge_mode is sampled on the transition cycle only. A mode change never produces a pulse by itself.
//  Sticky flag: set by pulse_out (same edge as pulse), cleared by flag_clr.
//   Simultaneous set and clear: flag stays 1 (set wins; no event lost). flag_clr with flag 0: no effect.
//  Channels are fully independent. Simultaneous events on any channel mix are each reported in the same cycle.
//  Minimum reliably detected input pulse: FILTER_LEN+1 clk periods. Shorter pulses may be missed by design.
// CONFIGURATION
//  SIGSYNC_OVERRUN_EN defined:
//   ovr_out[i] set when a new pulse occurs while flag_out[i]==1 and flag_clr[i]==0.
//   ovr_out[i] cleared by flag_clr[i] when no new overrun occurs that cycle (set wins).
//  SIGSYNC_OVERRUN_EN undefined: ovr_out tied to 0; no overrun logic synthesised. Port list unchanged.
// TESTING (CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=4, edge_mode=8'hFF unless stated)
//  1. reset_n low with sig_in=4'hF, release, hold
//     -> level_out=0 for 5 clks; at clk 6 level_out=4'hF, pulse_out=4'hF for 1 clk; flag_out=4'hF.
//  2. ch0 glitch high for 3 clks (sync_q high 3 cycles)
//     -> no level_out/pulse_out/flag change; glitch of 4 clks -> accepted, rising pulse.
//  3. ch1 edge_mode=01, drive high 10 clks then low
//     -> exactly one pulse (rising); falling edge gives level_out change, no pulse, no flag.
//  4. flag_clr[2] asserted on the same edge as a ch2 pulse -> flag_out[2] stays 1; flag_clr next cycle -> flag_out[2]=0.
//  5. SIGSYNC_OVERRUN_EN: two ch3 edges without clear -> ovr_out[3]=1 after second pulse; flag_clr -> both 0.
//     Without macro: ovr_out stays 4'h0.
//  6. reset_n pulsed low mid-filter (cnt=2) -> all outputs 0 immediately; no pulse after release if sig_in=0.

Source files
------------

// File: rtl/signal_sync_edge_flags.sv
// rtl/signal_sync_edge_flags.sv - multi-channel async input synchroniser, glitch filter and edge flag generator
//
// Purpose:
//   Each channel of sig_in is brought into the clk domain through a SYNC_STAGES-deep
//   flop chain and then glitch-filtered: a new level must be seen for FILTER_LEN
//   consecutive cycles before level_out follows it. On each accepted transition a
//   one-cycle pulse is emitted if edge_mode selects that edge direction, and a sticky
//   flag records it until flag_clr.
//
// Optional feature:
//   SIGSYNC_OVERRUN_EN - when defined, ovr_out[i] latches a pulse arriving while
//   flag_out[i] is still set and not being cleared. When undefined, ovr_out is 0.
//
// Ports:
//   clk        in   1            system clock, posedge
//   reset_n    in   1            asynchronous active-low reset
//   sig_in     in   CHANNELS     asynchronous inputs
//   edge_mode  in   2*CHANNELS   [2i]=rising enable, [2i+1]=falling enable
//   flag_clr   in   CHANNELS     sticky flag (and overrun) clear
//   level_out  out  CHANNELS     synchronised, filtered level
//   pulse_out  out  CHANNELS     one-cycle pulse per selected edge
//   flag_out   out  CHANNELS     sticky edge flag
//   ovr_out    out  CHANNELS     sticky overrun flag

module signal_sync_edge_flags #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     sig_in,
  input  logic [2*CHANNELS-1:0]   edge_mode,
  input  logic [CHANNELS-1:0]     flag_clr,
  output logic [CHANNELS-1:0]     level_out,
  output logic [CHANNELS-1:0]     pulse_out,
  output logic [CHANNELS-1:0]     flag_out,
  output logic [CHANNELS-1:0]     ovr_out
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_flag;
    logic                   w_sync_q;
    logic                   w_accept;
    logic                   w_pulse_set;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // The differing level has been seen on FILTER_LEN consecutive cycles once the
    // counter reaches FILTER_LEN-1 with sync_q still differing.
    assign w_accept = (w_sync_q != r_level) && (r_cnt == CNT_MAX);

    // sync_q is the new level on an accepted transition; edge_mode only matters here.
    assign w_pulse_set = w_accept && (w_sync_q ? edge_mode[2*gi] : edge_mode[2*gi+1]);

    // Plain shift chain, nothing between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[gi]};
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (w_sync_q == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= w_sync_q;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    // Flag is set on the same edge the pulse rises; set beats a concurrent clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pulse <= 1'b0;
        r_flag  <= 1'b0;
      end else begin
        r_pulse <= w_pulse_set;
        r_flag  <= w_pulse_set | (r_flag & ~flag_clr[gi]);
      end
    end

    assign level_out[gi] = r_level;
    assign pulse_out[gi] = r_pulse;
    assign flag_out[gi]  = r_flag;

`ifdef SIGSYNC_OVERRUN_EN
    logic r_ovr;
    logic w_ovr_set;

    // An event lands on a flag software has not yet acknowledged.
    assign w_ovr_set = w_pulse_set & r_flag & ~flag_clr[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= w_ovr_set | (r_ovr & ~flag_clr[gi]);
      end
    end

    assign ovr_out[gi] = r_ovr;
`else
    assign ovr_out[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_signal_sync_edge_flags.sv
// tb/tb_signal_sync_edge_flags.sv - directed self-checking bench for signal_sync_edge_flags

module tb_signal_sync_edge_flags;

  logic       clk;
  logic       reset_n;
  logic [3:0] sig_in;
  logic [7:0] edge_mode;
  logic [3:0] flag_clr;
  logic [3:0] level_out;
  logic [3:0] pulse_out;
  logic [3:0] flag_out;
  logic [3:0] ovr_out;

  int n_checks;
  int n_pass;
  int pulse_cnt [4];

  signal_sync_edge_flags #(
    .CHANNELS    (4),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .edge_mode (edge_mode),
    .flag_clr  (flag_clr),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .flag_out  (flag_out),
    .ovr_out   (ovr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pulse_out[i]) pulse_cnt[i]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_cnts();
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
  endtask

  task automatic clear_flags();
    flag_clr = 4'hF;
    tick();
    flag_clr = 4'h0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    clear_cnts();
    reset_n   = 1'b0;
    sig_in    = 4'hF;
    edge_mode = 8'hFF;
    flag_clr  = 4'h0;

    // 1. inputs high through reset release
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level_out, 4'h0);
    check("rst_pulse", pulse_out, 4'h0);
    check("rst_flag",  flag_out,  4'h0);
    check("rst_ovr",   ovr_out,   4'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("t1_level_clk%0d", k), level_out, 4'h0);
    end
    tick();
    check("t1_level_clk6", level_out, 4'hF);
    check("t1_pulse_clk6", pulse_out, 4'hF);
    check("t1_flag_clk6",  flag_out,  4'hF);
    tick();
    check("t1_pulse_clk7", pulse_out, 4'h0);
    check("t1_flag_clk7",  flag_out,  4'hF);

    // all channels fall; flags cleared on the first edge of the run
    sig_in   = 4'h0;
    flag_clr = 4'hF;
    tick();
    flag_clr = 4'h0;
    check("t1_flag_cleared", flag_out, 4'h0);
    ticks(5);
    check("t1_fall_level", level_out, 4'h0);
    check("t1_fall_pulse", pulse_out, 4'hF);
    check("t1_fall_flag",  flag_out,  4'hF);
    clear_flags();
    clear_cnts();

    // 2. ch0 glitch of 3 clocks is discarded
    sig_in = 4'h1;
    ticks(3);
    sig_in = 4'h0;
    ticks(10);
    check("t2_glitch3_pulses", pulse_cnt[0], 0);
    check("t2_glitch3_level",  level_out, 4'h0);
    check("t2_glitch3_flag",   flag_out,  4'h0);

    // 4-clock glitch is accepted, then its falling edge follows
    clear_cnts();
    sig_in = 4'h1;
    ticks(4);
    sig_in = 4'h0;
    ticks(1);
    check("t2_glitch4_level_clk5", level_out, 4'h0);
    ticks(1);
    check("t2_glitch4_level_clk6", level_out, 4'h1);
    check("t2_glitch4_pulse_clk6", pulse_out, 4'h1);
    check("t2_glitch4_flag_clk6",  flag_out,  4'h1);
    ticks(4);
    check("t2_fall_level_clk10", level_out, 4'h0);
    check("t2_fall_pulse_clk10", pulse_out, 4'h1);
    tick();
    check("t2_pulse_count", pulse_cnt[0], 2);
    clear_flags();
    clear_cnts();

    // 3. ch1 rising-only
    edge_mode = 8'b1111_0111;
    sig_in    = 4'h2;
    ticks(6);
    check("t3_rise_level", level_out, 4'h2);
    check("t3_rise_pulse", pulse_out, 4'h2);
    flag_clr = 4'h2;
    tick();
    flag_clr = 4'h0;
    check("t3_flag_cleared", flag_out, 4'h0);
    ticks(3);
    sig_in = 4'h0;
    ticks(5);
    check("t3_level_before_fall", level_out, 4'h2);
    tick();
    check("t3_fall_level", level_out, 4'h0);
    check("t3_fall_pulse", pulse_out, 4'h0);
    check("t3_fall_flag",  flag_out,  4'h0);
    ticks(2);
    check("t3_pulse_count", pulse_cnt[1], 1);
    edge_mode = 8'hFF;
    clear_cnts();

    // 4. clear coincident with ch2 pulse: set wins
    sig_in = 4'h4;
    ticks(5);
    flag_clr = 4'h4;
    tick();
    check("t4_pulse",        pulse_out, 4'h4);
    check("t4_flag_set_win", flag_out,  4'h4);
    tick();
    flag_clr = 4'h0;
    check("t4_flag_cleared", flag_out,  4'h0);
    check("t4_pulse_gone",   pulse_out, 4'h0);
    check("t4_no_ovr",       ovr_out,   4'h0);

    // 5. two ch3 events without clear
    clear_flags();
    sig_in = 4'hC;
    ticks(6);
    check("t5_first_pulse", pulse_out, 4'h8);
    check("t5_first_flag",  flag_out,  4'h8);
    check("t5_first_ovr",   ovr_out,   4'h0);
    sig_in = 4'h4;
    ticks(6);
    check("t5_second_pulse", pulse_out, 4'h8);
    check("t5_second_flag",  flag_out,  4'h8);
`ifdef SIGSYNC_OVERRUN_EN
    check("t5_second_ovr", ovr_out, 4'h8);
`else
    check("t5_second_ovr", ovr_out, 4'h0);
`endif
    flag_clr = 4'h8;
    tick();
    flag_clr = 4'h0;
    check("t5_clr_flag", flag_out, 4'h0);
    check("t5_clr_ovr",  ovr_out,  4'h0);

    // 6. reset mid-filter while ch2 is falling
    check("t6_level_before", level_out, 4'h4);
    sig_in = 4'h0;
    ticks(4);
    check("t6_level_mid_filter", level_out, 4'h4);
    clear_cnts();
    reset_n = 1'b0;
    #1;
    check("t6_async_level", level_out, 4'h0);
    check("t6_async_pulse", pulse_out, 4'h0);
    check("t6_async_flag",  flag_out,  4'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ticks(10);
    check("t6_no_pulse_ch2", pulse_cnt[2], 0);
    check("t6_level_after",  level_out, 4'h0);
    check("t6_flag_after",   flag_out,  4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
